// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory cacheline port between
// the I-cache and D-cache; one whole-line transaction in flight at a time.
module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    output logic [LINE_W-1:0] icache_rdata_o,
    output logic              icache_resp_o,
    input  logic              dcache_read_i,
    input  logic              dcache_write_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic [LINE_W-1:0] dcache_wdata_i,
    output logic [LINE_W-1:0] dcache_rdata_o,
    output logic              dcache_resp_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic [ADDR_W-1:0] pmem_addr_o,
    output logic [LINE_W-1:0] pmem_wdata_o,
    input  logic [LINE_W-1:0] pmem_rdata_i,
    input  logic              pmem_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   grant_d;

    assign i_req = icache_read_i;
    assign d_req = dcache_read_i | dcache_write_i;

    // D wins when alone, or on a tie when I was the most recent grant
    assign grant_d = d_req & (~i_req | ~last_d);

    assign icache_rdata_o = pmem_rdata_i;
    assign dcache_rdata_o = pmem_rdata_i;

    // Completion pulses are combinational; a reset cycle swallows the response
    assign icache_resp_o = (state == SERVE_I) & pmem_resp_i & ~rst;
    assign dcache_resp_o = (state == SERVE_D) & pmem_resp_i & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            pmem_read_o  <= 1'b0;
            pmem_write_o <= 1'b0;
            pmem_addr_o  <= '0;
            pmem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        last_d       <= 1'b1;
                        pmem_addr_o  <= dcache_addr_i;
                        pmem_wdata_o <= dcache_wdata_i;
                        // an illegal read+write request is treated as a write
                        pmem_write_o <= dcache_write_i;
                        pmem_read_o  <= ~dcache_write_i;
                    end else if (i_req) begin
                        state        <= SERVE_I;
                        last_d       <= 1'b0;
                        pmem_addr_o  <= icache_addr_i;
                        pmem_read_o  <= 1'b1;
                        pmem_write_o <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp_i) begin
                        state        <= IDLE;
                        pmem_read_o  <= 1'b0;
                        pmem_write_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    pmem_read_o  <= 1'b0;
                    pmem_write_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed table, hand-written corner
// sequences and a randomized phase against a transaction-level model.
module tb_cache_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              icache_read_i = 1'b0;
    logic [ADDR_W-1:0] icache_addr_i = '0;
    logic [LINE_W-1:0] icache_rdata_o;
    logic              icache_resp_o;
    logic              dcache_read_i = 1'b0;
    logic              dcache_write_i = 1'b0;
    logic [ADDR_W-1:0] dcache_addr_i = '0;
    logic [LINE_W-1:0] dcache_wdata_i = '0;
    logic [LINE_W-1:0] dcache_rdata_o;
    logic              dcache_resp_o;
    logic              pmem_read_o;
    logic              pmem_write_o;
    logic [ADDR_W-1:0] pmem_addr_o;
    logic [LINE_W-1:0] pmem_wdata_o;
    logic [LINE_W-1:0] pmem_rdata_i = '0;
    logic              pmem_resp_i = 1'b0;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read_i  (icache_read_i),
        .icache_addr_i  (icache_addr_i),
        .icache_rdata_o (icache_rdata_o),
        .icache_resp_o  (icache_resp_o),
        .dcache_read_i  (dcache_read_i),
        .dcache_write_i (dcache_write_i),
        .dcache_addr_i  (dcache_addr_i),
        .dcache_wdata_i (dcache_wdata_i),
        .dcache_rdata_o (dcache_rdata_o),
        .dcache_resp_o  (dcache_resp_o),
        .pmem_read_o    (pmem_read_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_addr_o    (pmem_addr_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_rdata_i   (pmem_rdata_i),
        .pmem_resp_i    (pmem_resp_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: who was granted last (0 none, 1 I, 2 D) and the write line held on the port
    int                prev_grant = 0;
    logic [LINE_W-1:0] wd_hold = '0;

    typedef struct {
        bit                i;
        bit                dr;
        bit                dw;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [LINE_W-1:0] wd;
        int                lat;
        bit                exp_d;
        bit                exp_wr;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < int'(LINE_W / 32); k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_all();
        icache_read_i  = 1'b0;
        dcache_read_i  = 1'b0;
        dcache_write_i = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        pmem_resp_i = 1'b0;
        rst = 1'b1;
        step();
        chk1("rst_read", pmem_read_o, 1'b0);
        chk1("rst_write", pmem_write_o, 1'b0);
        chkw("rst_addr", LINE_W'(pmem_addr_o), '0);
        chkw("rst_wdata", pmem_wdata_o, '0);
        chk1("rst_iresp", icache_resp_o, 1'b0);
        chk1("rst_dresp", dcache_resp_o, 1'b0);
        rst = 1'b0;
        prev_grant = 0;
        wd_hold = '0;
    endtask

    // Called in the IDLE cycle where the winning request is visible (cycle 0).
    // Memory answers at cycle lat; returns in the following IDLE cycle.
    task automatic txn(input bit srv_d, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr, input int lat);
        logic [LINE_W-1:0] line;
        if (srv_d) wd_hold = dcache_wdata_i;
        step();
        for (int c = 1; c <= lat; c++) begin
            // requester inputs wander during service; the port must not follow
            if (srv_d) begin
                dcache_addr_i  = $urandom;
                dcache_wdata_i = rnd_line();
            end else begin
                icache_addr_i = $urandom;
            end
            line         = rnd_line();
            pmem_rdata_i = line;
            pmem_resp_i  = (c == lat);
            #1;
            chk1("svc_read", pmem_read_o, ~exp_wr);
            chk1("svc_write", pmem_write_o, exp_wr);
            chkw("svc_addr", LINE_W'(pmem_addr_o), LINE_W'(exp_addr));
            chkw("svc_wdata", pmem_wdata_o, wd_hold);
            chk1("svc_iresp", icache_resp_o, ~srv_d && (c == lat));
            chk1("svc_dresp", dcache_resp_o, srv_d && (c == lat));
            if (c == lat) begin
                chkw("i_rdata", icache_rdata_o, line);
                chkw("d_rdata", dcache_rdata_o, line);
            end
            step();
        end
        pmem_resp_i = 1'b0;
        if (srv_d) begin
            dcache_read_i  = 1'b0;
            dcache_write_i = 1'b0;
        end else begin
            icache_read_i = 1'b0;
        end
        #1;
        chk1("idle_read", pmem_read_o, 1'b0);
        chk1("idle_write", pmem_write_o, 1'b0);
        chk1("idle_iresp", icache_resp_o, 1'b0);
        chk1("idle_dresp", dcache_resp_o, 1'b0);
        prev_grant = srv_d ? 2 : 1;
    endtask

    initial begin
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [ADDR_W-1:0] da2;

        tbl[0] = '{1, 0, 0, 32'h100, 32'h000, rnd_line(), 1, 0, 0, 32'h100};
        tbl[1] = '{1, 1, 0, 32'h140, 32'h200, rnd_line(), 2, 1, 0, 32'h200};
        tbl[2] = '{1, 0, 1, 32'h180, 32'h240, rnd_line(), 3, 0, 0, 32'h180};
        tbl[3] = '{1, 0, 1, 32'h1c0, 32'h280, rnd_line(), 1, 1, 1, 32'h280};
        tbl[4] = '{0, 1, 1, 32'h000, 32'h2c0, rnd_line(), 2, 1, 1, 32'h2c0};
        tbl[5] = '{1, 1, 0, 32'h300, 32'h340, rnd_line(), 1, 0, 0, 32'h300};
        tbl[6] = '{0, 1, 0, 32'h000, 32'h380, rnd_line(), 4, 1, 0, 32'h380};
        tbl[7] = '{1, 1, 1, 32'h3c0, 32'h400, rnd_line(), 2, 0, 0, 32'h3c0};

        step();
        do_reset();

        // I-only read of 0x40, memory answers after 5 cycles
        icache_read_i = 1'b1;
        icache_addr_i = 32'h0000_0040;
        txn(1'b0, 1'b0, 32'h0000_0040, 5);

        // D write-back of a known line
        dcache_write_i = 1'b1;
        dcache_addr_i  = 32'h0000_1000;
        dcache_wdata_i = {8{32'hDEAD_BEEF}};
        txn(1'b1, 1'b1, 32'h0000_1000, 4);
        chkw("wb_line_held", pmem_wdata_o, {8{32'hDEAD_BEEF}});

        // Tie from reset, then D keeps re-requesting: grants go D, I, D, I
        do_reset();
        ia = 32'h0000_5000;
        da = 32'h0000_6000;
        da2 = 32'h0000_7000;
        icache_read_i = 1'b1;
        icache_addr_i = ia;
        dcache_read_i = 1'b1;
        dcache_addr_i = da;
        txn(1'b1, 1'b0, da, 3);
        dcache_read_i = 1'b1;
        dcache_addr_i = da2;
        txn(1'b0, 1'b0, ia, 2);
        icache_read_i = 1'b1;
        icache_addr_i = ia + 32'h40;
        txn(1'b1, 1'b0, da2, 1);
        dcache_write_i = 1'b1;
        dcache_addr_i  = da + 32'h40;
        txn(1'b0, 1'b0, ia + 32'h40, 2);
        drop_all();

        // Reset in the middle of a D service, with memory answering in that cycle
        dcache_read_i = 1'b1;
        dcache_addr_i = 32'h0000_2000;
        step();
        step();
        chk1("pre_rst_read", pmem_read_o, 1'b1);
        rst = 1'b1;
        pmem_resp_i = 1'b1;
        #1;
        chk1("rst_cycle_dresp", dcache_resp_o, 1'b0);
        chk1("rst_cycle_iresp", icache_resp_o, 1'b0);
        step();
        rst = 1'b0;
        dcache_read_i = 1'b0;
        prev_grant = 0;
        wd_hold = '0;
        #1;
        chk1("post_rst_read", pmem_read_o, 1'b0);
        chk1("post_rst_write", pmem_write_o, 1'b0);
        chkw("post_rst_addr", LINE_W'(pmem_addr_o), '0);
        chkw("post_rst_wdata", pmem_wdata_o, '0);
        chk1("stray_dresp", dcache_resp_o, 1'b0);
        chk1("stray_iresp", icache_resp_o, 1'b0);
        step();
        pmem_resp_i = 1'b0;
        #1;
        chk1("stray_no_read", pmem_read_o, 1'b0);
        icache_read_i = 1'b1;
        icache_addr_i = 32'h0000_8000;
        dcache_read_i = 1'b1;
        dcache_addr_i = 32'h0000_9000;
        txn(1'b1, 1'b0, 32'h0000_9000, 2);
        drop_all();

        // Memory response in IDLE with nobody asking
        pmem_resp_i = 1'b1;
        #1;
        chk1("idle_resp_i", icache_resp_o, 1'b0);
        chk1("idle_resp_d", dcache_resp_o, 1'b0);
        step();
        pmem_resp_i = 1'b0;
        #1;
        chk1("idle_resp_noread", pmem_read_o, 1'b0);
        chk1("idle_resp_nowrite", pmem_write_o, 1'b0);

        // Directed table from a clean reset
        do_reset();
        foreach (tbl[n]) begin
            icache_read_i  = tbl[n].i;
            dcache_read_i  = tbl[n].dr;
            dcache_write_i = tbl[n].dw;
            icache_addr_i  = tbl[n].ia;
            dcache_addr_i  = tbl[n].da;
            dcache_wdata_i = tbl[n].wd;
            txn(tbl[n].exp_d, tbl[n].exp_wr, tbl[n].exp_addr, tbl[n].lat);
            drop_all();
        end

        // Randomized traffic against the transaction-level model
        for (int it = 0; it < 200; it++) begin
            bit ri;
            bit rdr;
            bit rdw;
            bit win_d;
            ri  = 1'($urandom_range(0, 1));
            rdr = 1'($urandom_range(0, 1));
            rdw = ($urandom_range(0, 3) == 0);
            icache_read_i  = ri;
            dcache_read_i  = rdr;
            dcache_write_i = rdw;
            icache_addr_i  = $urandom;
            dcache_addr_i  = $urandom;
            dcache_wdata_i = rnd_line();
            if (!ri && !rdr && !rdw) begin
                pmem_resp_i = 1'($urandom_range(0, 1));
                #1;
                chk1("rnd_idle_iresp", icache_resp_o, 1'b0);
                chk1("rnd_idle_dresp", dcache_resp_o, 1'b0);
                step();
                pmem_resp_i = 1'b0;
                #1;
                chk1("rnd_idle_read", pmem_read_o, 1'b0);
                chk1("rnd_idle_write", pmem_write_o, 1'b0);
            end else begin
                win_d = (rdr || rdw) && (!ri || prev_grant != 2);
                txn(win_d, win_d && rdw, win_d ? dcache_addr_i : icache_addr_i,
                    int'($urandom_range(1, 4)));
                drop_all();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
